pwm_dac: RTL and testbench
==========================

Name: pwm_dac

Overview:
- Output stage directly downstream of the amplitude-scaled function generator.
- Consumes its 8-bit sample stream and drives a single-bit PWM pin. An external RC filter turns that pin into the analog waveform.
- Double-buffers samples so duty changes only at PWM period boundaries, which keeps the output glitch-free.
- Flags samples it has to drop because the producer runs faster than the PWM frame rate.

Parameters:
- WIDTH, 8: sample and duty width; the PWM period is 2**WIDTH ticks.
- PRESCALE_W, 4: width of the runtime tick prescaler input.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- en  input  1  PWM run enable
- prescale  input  PRESCALE_W  tick divider; one tick every prescale+1 clk
- sample_in  input  WIDTH  sample from the amplitude selector
- sample_valid  input  1  sample_in valid this cycle
- sample_ready  output  1  block can accept a sample this cycle
- pwm_out  output  1  registered PWM output
- period_start  output  1  one-clk pulse on the first clk of each new period
- current_duty  output  WIDTH  duty value in force
- overrun  output  1  sticky flag: a sample was dropped

Behaviour:
- Reset values (after the rst clk edge):
  - pwm_out=0, period_start=0, current_duty=0, overrun=0
  - pending_full=0, so sample_ready=1
  - prescaler count=0, period counter cnt=0
- rst has priority over every other input, including mid-period.
- Prescaler:
  - pcnt increments each clk while en=1.
  - When pcnt >= prescale: tick=1 and pcnt<=0 in the same cycle.
  - The >= compare makes a mid-run prescale decrease safe.
  - prescale=0 gives a tick every clk.
- Period counter:
  - On tick, cnt increments modulo 2**WIDTH.
  - A wrap is tick && cnt==2**WIDTH-1.
- Load event: load = (!en) || wrap.
- Holding register (pending):
  - sample_ready = !pending_full || load (combinational).
  - accept = sample_valid && sample_ready.
  - On load with pending_full=1: current_duty<=pending.
  - On accept: pending<=sample_in and pending_full<=1.
  - On load without accept: pending_full<=0.
  - Load and accept in the same cycle: current_duty takes the old pending, pending takes the new sample, and pending_full stays 1.
  - If load occurs with pending_full=0, current_duty holds.
- Drop rule:
  - sample_valid && !sample_ready means the sample is discarded and overrun<=1.
  - overrun is cleared only by rst.
- en=0:
  - pcnt and cnt are forced to 0 and pwm_out<=0.
  - period_start stays 0.
  - Handshake stays live, and pending transfers to duty every cycle.
- PWM output:
  - pwm_out <= en && (cnt < current_duty), evaluated on the pre-edge values, so there is 1 clk latency.
  - duty=0 gives constant 0.
  - duty=2**WIDTH-1 gives high for 255 of 256 ticks.
  - Period = 2**WIDTH*(prescale+1) clk.
  - High time = duty*(prescale+1) clk.
- period_start <= en && wrap (registered). It is high in the clk where cnt==0 of the new period first appears.
- en rising edge: the first period starts at cnt=0 with the latest loaded duty. No period_start pulse is generated for this first period.

Decomposition:
- Shared package pwm_pkg holds:
  - the WIDTH/PRESCALE_W defaults
  - PERIOD_MAX = 2**WIDTH-1
- One sub-module, pwm_prescaler (en, prescale -> tick), reusable by the clock-divider path.
- Everything else lives in pwm_dac.

Test Plan:
- Reset: assert rst 3 clk with random inputs -> pwm_out=0, sample_ready=1, current_duty=0, overrun=0, period_start=0; rst mid-period at cnt=100 -> all outputs at reset values next clk.
- Basic duty: prescale=0, en=1, send 64 once -> current_duty=64 after the first wrap; thereafter pwm_out high exactly 64 of every 256 clk, and period_start pulses every 256 clk.
- Extremes: duty 0 -> pwm_out never high across 3 periods; duty 255 -> high 255 clk, low 1 clk per period.
- Prescale: prescale=3, duty=128 -> period 1024 clk, high 512 clk; change prescale to 1 mid-period -> no hang, next period 512 clk.
- Overrun: prescale=0, send 10 at cnt=5, then 20 at cnt=50 -> 20 dropped, sample_ready=0, overrun=1 sticky; at wrap current_duty=10.
- Simultaneous: pending=30, send 40 on the exact wrap clk -> accepted (ready=1), current_duty=30, pending=40, next wrap current_duty=40, overrun stays 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and helpers for the PWM DAC output stage.
//   WIDTH_DEF      - default sample/duty width (PWM period is 2**WIDTH ticks)
//   PRESCALE_W_DEF - default width of the runtime tick prescaler input
//   PERIOD_MAX     - last period-counter value for the default width
//   period_max()   - last period-counter value for an arbitrary width
package pwm_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned PRESCALE_W_DEF = 4;
  localparam int unsigned PERIOD_MAX     = (1 << WIDTH_DEF) - 1;

  function automatic int unsigned period_max(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: runtime-programmable tick divider.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   en       in   run enable; when low the count is held at zero and no ticks issue
//   prescale in   divider; one tick every prescale+1 clk
//   tick     out  combinational tick strobe
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    // >= rather than == so lowering prescale below the running count cannot
    // strand the counter until it wraps around its full range.
    tick   = en && (pcnt_q >= prescale);
    pcnt_d = pcnt_q + PRESCALE_W'(1);
    if (!en || tick) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: single-bit PWM output stage with double-buffered duty.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   en           in   PWM run enable
//   prescale     in   tick divider; one tick every prescale+1 clk
//   sample_in    in   sample from the amplitude selector
//   sample_valid in   sample_in valid this cycle
//   sample_ready out  block can accept a sample this cycle
//   pwm_out      out  registered PWM output
//   period_start out  one-clk pulse on the first clk of each new period
//   current_duty out  duty value in force
//   overrun      out  sticky flag: a sample was dropped
module pwm_dac
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic [WIDTH-1:0]      current_duty,
  output logic                  overrun
);

  localparam logic [WIDTH-1:0] CntMax = WIDTH'(period_max(WIDTH));

  logic             tick;
  logic             wrap;
  logic             load;
  logic             accept;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_full_q, pending_full_d;
  logic             pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             overrun_q, overrun_d;

  pwm_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    wrap = tick && (cnt_q == CntMax);
    // While disabled the duty tracks the holding register every cycle, so a
    // freshly enabled run starts with the latest sample.
    load         = !en || wrap;
    sample_ready = !pending_full_q || load;
    accept       = sample_valid && sample_ready;

    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    duty_d = duty_q;
    if (load && pending_full_q) begin
      duty_d = pending_q;
    end

    // Accept wins over load: when both happen, the old pending moves into
    // the duty and the new sample refills the holding register.
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    if (accept) begin
      pending_d      = sample_in;
      pending_full_d = 1'b1;
    end else if (load) begin
      pending_full_d = 1'b0;
    end

    overrun_d      = overrun_q || (sample_valid && !sample_ready);
    pwm_d          = en && (cnt_q < duty_q);
    period_start_d = en && wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      overrun_q      <= overrun_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign current_duty = duty_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed self-checking bench for pwm_dac.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pwm_dac;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] prescale;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       pwm_out;
  logic       period_start;
  logic [7:0] current_duty;
  logic       overrun;

  int checks;
  int failures;

  pwm_dac #(
    .WIDTH      (8),
    .PRESCALE_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .prescale     (prescale),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .current_duty (current_duty),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge showing period_start, bounded.
  task automatic sync_period(output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < 5000) begin
      @(negedge clk);
      if (period_start === 1'b1) ok = 1'b1;
      i++;
    end
  endtask

  // Count pwm_out highs and period_start pulses over n negedges.
  task automatic measure(input int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) hi++;
      if (period_start === 1'b1) ps++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst          = 1'b1;
    en           = 1'b0;
    prescale     = 4'd0;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    wait_clks(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      en           = 1'($urandom_range(0, 1));
      prescale     = 4'($urandom);
      sample_in    = 8'($urandom);
      sample_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL rst_pwm_out: got %b want 0", pwm_out); end
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL rst_sample_ready: got %b want 1", sample_ready); end
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL rst_current_duty: got %0d want 0", current_duty); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL rst_period_start: got %b want 0", period_start); end

    // Load duty 200 while disabled, run to cnt=100 with an overrun, then reset.
    rst = 1'b0; en = 1'b0; prescale = 4'd0; sample_in = 8'd200; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 48) begin sample_in = 8'd7; sample_valid = 1'b1; end
      if (k == 49) begin sample_in = 8'd9; sample_valid = 1'b1; end
      if (k == 50) sample_valid = 1'b0;
    end
    checks++; if (current_duty !== 8'd200) begin failures++; $display("FAIL mid_duty: got %0d want 200", current_duty); end
    checks++; if (pwm_out !== 1'b1) begin failures++; $display("FAIL mid_pwm_out: got %b want 1", pwm_out); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL mid_overrun: got %b want 1", overrun); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL mid_sample_ready: got %b want 0", sample_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL midrst_pwm_out: got %b want 0", pwm_out); end
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL midrst_duty: got %0d want 0", current_duty); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL midrst_sample_ready: got %b want 1", sample_ready); end
    checks++; if (period_start !== 1'b0) begin failures++; $display("FAIL midrst_period_start: got %b want 0", period_start); end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_basic_duty();
    bit ok;
    int hi, ps;
    apply_reset();
    en = 1'b1; sample_in = 8'd64; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sync_period(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_sync: got %b want 1", ok); end
    checks++; if (current_duty !== 8'd64) begin failures++; $display("FAIL basic_duty: got %0d want 64", current_duty); end
    for (int p = 0; p < 2; p++) begin
      measure(256, hi, ps);
      checks++; if (hi !== 64) begin failures++; $display("FAIL basic_high[%0d]: got %0d want 64", p, hi); end
      checks++; if (ps !== 1) begin failures++; $display("FAIL basic_pulses[%0d]: got %0d want 1", p, ps); end
      checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL basic_period_end[%0d]: got %b want 1", p, period_start); end
    end
  endtask

  task automatic test_disable();
    bit ok;
    int hi, ps;
    apply_reset();
    en = 1'b1; sample_in = 8'd64; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sync_period(ok);
    wait_clks(20);
    en = 1'b0; sample_in = 8'd77; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    checks++; if (current_duty !== 8'd77) begin failures++; $display("FAIL dis_duty: got %0d want 77", current_duty); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL dis_pwm_out: got %b want 0", pwm_out); end
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL dis_sample_ready: got %b want 1", sample_ready); end
    en = 1'b1;
    measure(256, hi, ps);
    checks++; if (hi !== 77) begin failures++; $display("FAIL dis_first_high: got %0d want 77", hi); end
    checks++; if (ps !== 1) begin failures++; $display("FAIL dis_first_pulses: got %0d want 1", ps); end
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL dis_first_end: got %b want 1", period_start); end
  endtask

  task automatic test_extremes();
    bit ok;
    int hi, ps;
    apply_reset();
    en = 1'b1; sample_in = 8'd0; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sync_period(ok);
    checks++; if (current_duty !== 8'd0) begin failures++; $display("FAIL ext0_duty: got %0d want 0", current_duty); end
    measure(768, hi, ps);
    checks++; if (hi !== 0) begin failures++; $display("FAIL ext0_high: got %0d want 0", hi); end
    checks++; if (ps !== 3) begin failures++; $display("FAIL ext0_pulses: got %0d want 3", ps); end
    sample_in = 8'd255; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sync_period(ok);
    checks++; if (current_duty !== 8'd255) begin failures++; $display("FAIL ext255_duty: got %0d want 255", current_duty); end
    measure(256, hi, ps);
    checks++; if (hi !== 255) begin failures++; $display("FAIL ext255_high: got %0d want 255", hi); end
    checks++; if (pwm_out !== 1'b0) begin failures++; $display("FAIL ext255_low_slot: got %b want 0", pwm_out); end
  endtask

  task automatic test_prescale();
    bit ok;
    int hi, ps;
    apply_reset();
    prescale = 4'd3; en = 1'b1; sample_in = 8'd128; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sync_period(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pre_sync: got %b want 1", ok); end
    checks++; if (current_duty !== 8'd128) begin failures++; $display("FAIL pre_duty: got %0d want 128", current_duty); end
    measure(1024, hi, ps);
    checks++; if (hi !== 512) begin failures++; $display("FAIL pre3_high: got %0d want 512", hi); end
    checks++; if (ps !== 1) begin failures++; $display("FAIL pre3_pulses: got %0d want 1", ps); end
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL pre3_end: got %b want 1", period_start); end
    wait_clks(301);
    prescale = 4'd1;
    sync_period(ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pre_change_sync: got %b want 1", ok); end
    measure(512, hi, ps);
    checks++; if (hi !== 256) begin failures++; $display("FAIL pre1_high: got %0d want 256", hi); end
    checks++; if (ps !== 1) begin failures++; $display("FAIL pre1_pulses: got %0d want 1", ps); end
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL pre1_end: got %b want 1", period_start); end
  endtask

  task automatic test_overrun();
    bit ok;
    int hi, ps;
    apply_reset();
    en = 1'b1;
    sync_period(ok);
    wait_clks(5);
    sample_in = 8'd10; sample_valid = 1'b1;
    #1;
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL ovr_ready_first: got %b want 1", sample_ready); end
    @(negedge clk);
    sample_valid = 1'b0;
    wait_clks(44);
    sample_in = 8'd20; sample_valid = 1'b1;
    #1;
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL ovr_ready_second: got %b want 0", sample_ready); end
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    sync_period(ok);
    checks++; if (current_duty !== 8'd10) begin failures++; $display("FAIL ovr_duty: got %0d want 10", current_duty); end
    measure(256, hi, ps);
    checks++; if (hi !== 10) begin failures++; $display("FAIL ovr_high: got %0d want 10", hi); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    en = 1'b1;
    sync_period(ok);
    sample_in = 8'd30; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_clks(254);
    sample_in = 8'd40; sample_valid = 1'b1;
    #1;
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_wrap: got %b want 1", sample_ready); end
    @(negedge clk);
    sample_valid = 1'b0;
    checks++; if (period_start !== 1'b1) begin failures++; $display("FAIL b2b_period_start: got %b want 1", period_start); end
    checks++; if (current_duty !== 8'd30) begin failures++; $display("FAIL b2b_duty_old: got %0d want 30", current_duty); end
    checks++; if (sample_ready !== 1'b0) begin failures++; $display("FAIL b2b_pending_full: got %b want 0", sample_ready); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    sync_period(ok);
    checks++; if (current_duty !== 8'd40) begin failures++; $display("FAIL b2b_duty_new: got %0d want 40", current_duty); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun_end: got %b want 0", overrun); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    en           = 1'b0;
    prescale     = 4'd0;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    test_reset();
    test_basic_duty();
    test_disable();
    test_extremes();
    test_prescale();
    test_overrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
